borders_collision: RTL and testbench
====================================

// Module: borders_collision
// PURPOSE
//  Consumer end of the borders drawing-request interface. Watches drawingRequestBorders and
//  drawingRequestBall on every scanned pixel, and classifies overlaps by table side.
//  Once per frame it emits one-cycle collision pulses for the ball-motion logic, with a
//  per-side hold-off so a ball still inside a cushion is not re-bounced.
// PARAMETERS
//  TOP_OFFSET      0  first on-table row; rows above it are the top cushion
//  DOWN_OFFSET     0  last on-table row; rows below it are the bottom cushion
//  LEFT_OFFSET     0  first on-table column; columns left of it are the left cushion
//  RIGHT_OFFSET    0  last on-table column; columns right of it are the right cushion
//  HOLDOFF_FRAMES  2  frames a side stays suppressed after it reports (1..15)
// PORTS
//  clk                    in   1   pixel clock
//  resetN                 in   1   asynchronous, active-low reset
//  startOfFrame           in   1   one-cycle pulse at the first pixel of each frame
//  pixelX                 in   11  signed current scan column (same bus the drawers see)
//  pixelY                 in   11  signed current scan row
//  drawingRequestBall     in   1   ball drawer request, registered (1-cycle latency)
//  drawingRequestBorders  in   1   borders drawer request, registered (1-cycle latency)
//  collisionTop           out  1   one-cycle pulse: top cushion hit last frame
//  collisionDown          out  1   one-cycle pulse: bottom cushion hit last frame
//  collisionLeft          out  1   one-cycle pulse: left cushion hit last frame
//  collisionRight         out  1   one-cycle pulse: right cushion hit last frame
//  collisionAny           out  1   OR of the four pulses, same cycle
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, hit flags 0, hold-off counters 0, pixel delay regs 0.
//  - Alignment: pixelX/pixelY are registered once internally. A request pair at cycle n
//    is classified with the coordinates from cycle n-1.
//  - FSM states:
//    - IDLE: all hits are ignored.
//    - IDLE -> ACCUM on the first startOfFrame.
//    - ACCUM: stays in ACCUM until reset.
//  - Overlap = drawingRequestBall && drawingRequestBorders.
//  - In ACCUM, an overlap sets hit flags from the delayed coordinates:
//    - top:   Y < TOP_OFFSET
//    - down:  Y > DOWN_OFFSET
//    - left:  X < LEFT_OFFSET
//    - right: X > RIGHT_OFFSET
//    A corner pixel may set two flags.
//  - Comparisons are signed 11-bit, so negative coordinates count as top/left.
//  - On startOfFrame in ACCUM, each side reports in the following cycle:
//    - pulse = hit flag && holdoff counter == 0;
//    - a reporting side loads its counter with HOLDOFF_FRAMES;
//    - a non-reporting side with a nonzero counter decrements by 1 (saturates at 0).
//  - All four hit flags clear in the same startOfFrame cycle.
//  - An overlap coinciding with startOfFrame belongs to the new frame: it sets its flag
//    after the clear.
//  - Latency: the pulses go high exactly 1 cycle after startOfFrame and last exactly 1
//    cycle. There are no pulses on any other cycle.
//  - A second startOfFrame before any overlap produces no pulses; counters still
//    decrement.
//  - Mid-frame reset returns to IDLE: the partial frame is discarded and hold-offs clear.
//  - Overlaps with no side condition true (inconsistent inputs) set no flag.
// TESTING
//  - T1, params 20/459/20/619: resetN low, then release with no startOfFrame; inject an
//    overlap at (5,100) -> all outputs stay 0 (IDLE).
//  - T2: startOfFrame; overlap at delayed (100,10); next startOfFrame -> collisionTop and
//    collisionAny = 1 for exactly 1 cycle, 1 cycle after the pulse.
//  - T3: overlap at (5,470) (corner) -> collisionLeft and collisionDown pulse together;
//    collisionTop and collisionRight stay 0.
//  - T4, HOLDOFF=2: right hit in frames 1, 2, 3 and 4 -> pulses at the end of frames 1
//    and 4 only.
//  - T5: overlap asserted in the same cycle as startOfFrame at (630,200) -> no pulse now;
//    collisionRight pulses at the next frame end.
//  - T6: left hit mid-frame, then resetN low for 1 cycle, then 2 frames with no overlaps
//    -> no pulses at all.

Source files
------------

// File: rtl/borders_collision.sv
// Borders/ball overlap classifier: accumulates per-side cushion hits over a frame and
// emits one-cycle collision pulses after each startOfFrame, with a per-side hold-off.
module borders_collision #(
  parameter int TOP_OFFSET     = 0,
  parameter int DOWN_OFFSET    = 0,
  parameter int LEFT_OFFSET    = 0,
  parameter int RIGHT_OFFSET   = 0,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        drawingRequestBall,
  input  logic        drawingRequestBorders,
  output logic        collisionTop,
  output logic        collisionDown,
  output logic        collisionLeft,
  output logic        collisionRight,
  output logic        collisionAny
);

  localparam logic signed [10:0] TOP_LIM   = TOP_OFFSET[10:0];
  localparam logic signed [10:0] DOWN_LIM  = DOWN_OFFSET[10:0];
  localparam logic signed [10:0] LEFT_LIM  = LEFT_OFFSET[10:0];
  localparam logic signed [10:0] RIGHT_LIM = RIGHT_OFFSET[10:0];
  localparam logic [3:0]         HOLD_LOAD = HOLDOFF_FRAMES[3:0];

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             r_state;
  logic signed [10:0] r_pixelX;
  logic signed [10:0] r_pixelY;
  logic [3:0]         r_hit;
  logic [3:0][3:0]    r_hold;
  logic [3:0]         r_pulse;
  logic               r_any;

  logic               w_overlap;
  logic [3:0]         w_side;
  logic [3:0]         w_ready;
  logic [3:0]         w_report;

  // Side index order: 0 top, 1 down, 2 left, 3 right. Coordinates are the delayed ones,
  // which line up with the drawers' registered requests.
  assign w_overlap = drawingRequestBall && drawingRequestBorders;
  assign w_side[0] = r_pixelY < TOP_LIM;
  assign w_side[1] = r_pixelY > DOWN_LIM;
  assign w_side[2] = r_pixelX < LEFT_LIM;
  assign w_side[3] = r_pixelX > RIGHT_LIM;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < 4; i++) begin
      w_ready[i] = (r_hold[i] == 4'd0);
    end
  end

  assign w_report = r_hit & w_ready;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_pixelX <= '0;
      r_pixelY <= '0;
      r_hit    <= '0;
      r_hold   <= '0;
      r_pulse  <= '0;
      r_any    <= 1'b0;
    end else begin
      r_pixelX <= pixelX;
      r_pixelY <= pixelY;
      r_pulse  <= '0;
      r_any    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (startOfFrame) r_state <= ACCUM;
        end
        ACCUM: begin
          if (startOfFrame) begin
            r_pulse <= w_report;
            r_any   <= |w_report;
            for (int i = 0; i < 4; i++) begin
              if (w_report[i]) r_hold[i] <= HOLD_LOAD;
              else if (!w_ready[i]) r_hold[i] <= r_hold[i] - 4'd1;
            end
            // A coincident overlap already belongs to the frame that is starting.
            r_hit <= w_overlap ? w_side : 4'b0000;
          end else if (w_overlap) begin
            r_hit <= r_hit | w_side;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign collisionTop   = r_pulse[0];
  assign collisionDown  = r_pulse[1];
  assign collisionLeft  = r_pulse[2];
  assign collisionRight = r_pulse[3];
  assign collisionAny   = r_any;

endmodule

// File: tb/tb_borders_collision.sv
// Bench for borders_collision: directed scenarios followed by random traffic, all checked
// cycle by cycle against a frame-level reference model.
module tb_borders_collision;

  localparam int TOP = 20;
  localparam int DOWN = 459;
  localparam int LEFT = 20;
  localparam int RIGHT = 619;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        drawingRequestBall = 1'b0;
  logic        drawingRequestBorders = 1'b0;
  logic        collisionTop, collisionDown, collisionLeft, collisionRight, collisionAny;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: whether frames are being tracked, hits seen this frame,
  // frames left before each side may report again, and last cycle's coordinates.
  bit       mActive;
  bit       mHit[4];
  int       mHold[4];
  int       mPrevX, mPrevY;
  bit [4:0] mExp;

  borders_collision #(
    .TOP_OFFSET(TOP), .DOWN_OFFSET(DOWN), .LEFT_OFFSET(LEFT), .RIGHT_OFFSET(RIGHT),
    .HOLDOFF_FRAMES(HOLD)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .drawingRequestBall(drawingRequestBall), .drawingRequestBorders(drawingRequestBorders),
    .collisionTop(collisionTop), .collisionDown(collisionDown),
    .collisionLeft(collisionLeft), .collisionRight(collisionRight),
    .collisionAny(collisionAny)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mActive = 0;
    mPrevX = 0;
    mPrevY = 0;
    mExp = '0;
    for (int s = 0; s < 4; s++) begin
      mHit[s] = 0;
      mHold[s] = 0;
    end
  endfunction

  function automatic void modelEdge();
    logic signed [10:0] sx, sy;
    bit pulse[4];
    bit side[4];
    for (int s = 0; s < 4; s++) pulse[s] = 0;
    if (mActive && startOfFrame) begin
      for (int s = 0; s < 4; s++) begin
        if (mHit[s] && mHold[s] == 0) begin
          pulse[s] = 1;
          mHold[s] = HOLD;
        end else if (mHold[s] > 0) begin
          mHold[s] = mHold[s] - 1;
        end
        mHit[s] = 0;
      end
    end
    if (mActive && drawingRequestBall && drawingRequestBorders) begin
      side[0] = mPrevY < TOP;
      side[1] = mPrevY > DOWN;
      side[2] = mPrevX < LEFT;
      side[3] = mPrevX > RIGHT;
      for (int s = 0; s < 4; s++) mHit[s] = mHit[s] | side[s];
    end
    if (startOfFrame) mActive = 1;
    sx = pixelX;
    sy = pixelY;
    mPrevX = int'(sx);
    mPrevY = int'(sy);
    mExp = {pulse[0] | pulse[1] | pulse[2] | pulse[3], pulse[3], pulse[2], pulse[1], pulse[0]};
  endfunction

  task automatic checkOutput(input string tag);
    logic [4:0] got;
    got = {collisionAny, collisionRight, collisionLeft, collisionDown, collisionTop};
    vectors++;
    assert (got === mExp) else begin
      miscompares++;
      $error("FAIL %s got=%b exp=%b (any,right,left,down,top)", tag, got, mExp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic sof, input int x, input int y,
                               input logic ball, input logic bord);
    @(negedge clk);
    startOfFrame = sof;
    pixelX = x[10:0];
    pixelY = y[10:0];
    drawingRequestBall = ball;
    drawingRequestBorders = bord;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 1'b0;
    drawingRequestBall = 1'b0;
    drawingRequestBorders = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput(tag);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Coordinates presented one cycle ahead of the request pair, as the drawers do.
  task automatic overlapAt(input string tag, input int x, input int y);
    applyStimulus(tag, 1'b0, x, y, 1'b0, 1'b0);
    applyStimulus(tag, 1'b0, 0, 0, 1'b1, 1'b1);
    applyStimulus(tag, 1'b0, 300, 200, 1'b0, 1'b0);
  endtask

  task automatic frameEnd(input string tag);
    applyStimulus(tag, 1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(tag, 1'b0, 300, 200, 1'b0, 1'b0);
    applyStimulus(tag, 1'b0, 300, 200, 1'b0, 1'b0);
  endtask

  initial begin
    modelReset();
    doReset("reset");

    // T1: idle before the first frame, overlaps ignored
    overlapAt("t1_idle", 5, 100);
    applyStimulus("t1_idle", 1'b0, 10, 10, 1'b1, 1'b1);
    applyStimulus("t1_idle", 1'b0, 10, 10, 1'b0, 1'b0);

    // T2: top hit
    frameEnd("t2_start");
    overlapAt("t2_top", 100, 10);
    frameEnd("t2_pulse");

    // T3: corner sets left and down
    overlapAt("t3_corner", 5, 470);
    frameEnd("t3_pulse");

    // T4: right hit four frames in a row, hold-off suppresses frames 2 and 3
    for (int f = 0; f < 4; f++) begin
      overlapAt("t4_right", 630, 200);
      frameEnd("t4_pulse");
    end

    // drain hold-offs, including a frame with no overlap at all
    frameEnd("drain");
    frameEnd("drain");

    // T5: overlap coincident with startOfFrame counts toward the new frame
    applyStimulus("t5_setup", 1'b0, 630, 200, 1'b0, 1'b0);
    applyStimulus("t5_sof", 1'b1, 0, 0, 1'b1, 1'b1);
    applyStimulus("t5_nopulse", 1'b0, 300, 200, 1'b0, 1'b0);
    frameEnd("t5_pulse");

    // inconsistent overlap on-table and negative coordinates
    overlapAt("ontable", 300, 200);
    overlapAt("negative", -5, -3);
    frameEnd("neg_pulse");

    // T6: mid-frame reset discards the partial frame
    overlapAt("t6_left", 5, 200);
    doReset("t6_reset");
    frameEnd("t6_frame");
    frameEnd("t6_frame");
    frameEnd("t6_frame");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic sof, b, d;
      int x, y;
      sof = ($urandom_range(0, 19) == 0);
      x = int'($urandom_range(0, 760)) - 60;
      y = int'($urandom_range(0, 560)) - 60;
      b = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 499) == 0) doReset("rand_reset");
      else applyStimulus("random", sof, x, y, b, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
